// File: rtl/rsd_pkg.sv
// Shared helpers for the radix-r signed-digit adder: digit sizing and the
// digit-slice convention (digit i lives at [i*D +: D], digit 0 least significant).
package rsd_pkg;

    localparam int unsigned RsdMinRadix = 4;

    function automatic int unsigned rsd_digit_bits(input int unsigned radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int unsigned rsd_max_digit(input int unsigned radix);
        return radix - 1;
    endfunction

    function automatic int unsigned rsd_digit_lsb(input int unsigned idx, input int unsigned bits);
        return idx * bits;
    endfunction

endpackage

// File: rtl/rsd_digit_tw.sv
// One digit position of the signed-digit adder: forms x+/-y and splits it into a
// transfer digit t (-1, 0, +1) and an interim digit w so that p = RADIX*t + w.
module rsd_digit_tw
    import rsd_pkg::*;
#(
    parameter int unsigned RADIX = 8,
    parameter int unsigned D     = rsd_digit_bits(RADIX)
) (
    input  logic [D-1:0] x_i,
    input  logic [D-1:0] y_i,
    input  logic         sub_i,
    output logic [1:0]   t_o,
    output logic [D-1:0] w_o,
    output logic         err_o
);

    localparam int unsigned A = rsd_max_digit(RADIX);
    localparam logic signed [D:0] PosLim = (D+1)'(A);
    localparam logic signed [D:0] NegLim = -PosLim;
    localparam logic signed [D:0] RadixS = (D+1)'(RADIX);

    logic signed [D:0] x_ext;
    logic signed [D:0] y_ext;
    logic signed [D:0] y_eff;
    logic signed [D:0] p;

    always_comb begin
        x_ext = {x_i[D-1], x_i};
        y_ext = {y_i[D-1], y_i};
        // One extra bit keeps the negation exact even for an out-of-range y digit.
        y_eff = sub_i ? -y_ext : y_ext;
        p     = x_ext + y_eff;
        err_o = (x_ext > PosLim) || (x_ext < NegLim) || (y_ext > PosLim) || (y_ext < NegLim);
        if (p >= PosLim) begin
            t_o = 2'b01;
            w_o = D'(p - RadixS);
        end else if (p <= NegLim) begin
            t_o = 2'b11;
            w_o = D'(p + RadixS);
        end else begin
            t_o = 2'b00;
            w_o = D'(p);
        end
    end

endmodule

// File: rtl/rsd_add_pipe.sv
// Two-stage pipelined signed-digit adder/subtractor with valid/ready flow control.
// Stage 1 holds per-digit (t, w) pairs; stage 2 absorbs each transfer into the next digit.
module rsd_add_pipe
    import rsd_pkg::*;
#(
    parameter int unsigned RADIX = 8,
    parameter int unsigned WIDTH = 5,
    localparam int unsigned D    = rsd_digit_bits(RADIX),
    localparam int unsigned N    = D * WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           sub,
    input  logic [N-1:0]   x_in,
    input  logic [N-1:0]   y_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+D-1:0] s_out,
    output logic           err_out
);

    if (RADIX < RsdMinRadix) begin : g_bad_radix
        $error("rsd_add_pipe: RADIX must be at least 4");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("rsd_add_pipe: WIDTH must be at least 1");
    end

    function automatic logic [D-1:0] t_sext(input logic [1:0] t);
        return {{(D-2){t[1]}}, t};
    endfunction

    // Stage 1: per-digit transfer/interim split
    logic [WIDTH-1:0][1:0]   t_d;
    logic [WIDTH-1:0][D-1:0] w_d;
    logic [WIDTH-1:0]        err_dig;

    for (genvar i = 0; i < WIDTH; i++) begin : g_digit
        rsd_digit_tw #(
            .RADIX (RADIX),
            .D     (D)
        ) u_digit (
            .x_i   (x_in[rsd_digit_lsb(i, D) +: D]),
            .y_i   (y_in[rsd_digit_lsb(i, D) +: D]),
            .sub_i (sub),
            .t_o   (t_d[i]),
            .w_o   (w_d[i]),
            .err_o (err_dig[i])
        );
    end

    logic                    s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0][1:0]   t_q;
    logic [WIDTH-1:0][D-1:0] w_q;
    logic                    err1_q;

    logic                    out_valid_q, out_valid_d;
    logic [N+D-1:0]          s_q, s_d;
    logic                    err_q;

    logic                    s2_adv;
    logic                    in_fire;
    logic                    s2_load;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = s2_adv && s1_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    end

    // Stage 2: each digit takes the transfer from the digit below it; the top
    // digit is the final transfer alone.
    always_comb begin
        s_d = '0;
        s_d[0 +: D] = w_q[0];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            s_d[rsd_digit_lsb(i, D) +: D] = w_q[i] + t_sext(t_q[i-1]);
        end
        s_d[rsd_digit_lsb(WIDTH, D) +: D] = t_sext(t_q[WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            t_q         <= '0;
            w_q         <= '0;
            err1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                t_q    <= t_d;
                w_q    <= w_d;
                err1_q <= |err_dig;
            end
            if (s2_load) begin
                s_q   <= s_d;
                err_q <= err1_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s_out     = s_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_rsd_add_pipe.sv
// Scoreboard bench for rsd_add_pipe: a radix-8 instance for directed, flow-control
// and random checks, plus a radix-4 instance for random value-identity checks.
module tb_rsd_add_pipe;

    localparam int unsigned R8 = 8;
    localparam int unsigned W8 = 5;
    localparam int unsigned D8 = 4;
    localparam int unsigned N8 = D8 * W8;
    localparam int unsigned R4 = 4;
    localparam int unsigned W4 = 3;
    localparam int unsigned D4 = 3;
    localparam int unsigned N4 = D4 * W4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic             in_valid, in_ready, sub, out_valid, out_ready, err_out;
    logic [N8-1:0]    x_in, y_in;
    logic [N8+D8-1:0] s_out;

    logic             in_valid4, in_ready4, sub4, out_valid4, out_ready4, err_out4;
    logic [N4-1:0]    x_in4, y_in4;
    logic [N4+D4-1:0] s_out4;

    rsd_add_pipe #(
        .RADIX (R8),
        .WIDTH (W8)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .err_out   (err_out)
    );

    rsd_add_pipe #(
        .RADIX (R4),
        .WIDTH (W4)
    ) u_dut4 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .sub       (sub4),
        .x_in      (x_in4),
        .y_in      (y_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .s_out     (s_out4),
        .err_out   (err_out4)
    );

    typedef struct {
        logic [63:0] s;
        longint      val;
        bit          chk_s;
        bit          chk_val;
        bit          err;
    } sb_t;

    sb_t    q8[$];
    sb_t    q4[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    bit     rand_ready = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at t=%0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic longint dig_at(input logic [63:0] v, input int i, input int d);
        logic [63:0] sh;
        longint dig;
        sh  = v >> (i * d);
        dig = longint'(sh & ((64'd1 << d) - 64'd1));
        if (dig >= (longint'(1) << (d - 1))) dig -= (longint'(1) << d);
        return dig;
    endfunction

    function automatic longint rsd_value(input logic [63:0] v, input int r, input int d,
                                         input int n);
        longint acc = 0;
        for (int i = n - 1; i >= 0; i--) acc = acc * r + dig_at(v, i, d);
        return acc;
    endfunction

    function automatic int range_bad(input logic [63:0] v, input int r, input int d, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (dig_at(v, i, d) > r - 1 || dig_at(v, i, d) < -(r - 1)) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [63:0] rand_op(input int r, input int d, input int n);
        logic [63:0] v = '0;
        int dig;
        for (int i = 0; i < n; i++) begin
            dig = int'($urandom_range(0, 2 * (r - 1))) - (r - 1);
            v = v | ((64'(dig) & ((64'd1 << d) - 64'd1)) << (i * d));
        end
        return v;
    endfunction

    function automatic sb_t mk_val(input logic [63:0] x, input logic [63:0] y, input bit s,
                                   input int r, input int d, input int n);
        sb_t e;
        e.s       = '0;
        e.chk_s   = 1'b0;
        e.chk_val = 1'b1;
        e.err     = 1'b0;
        e.val     = s ? rsd_value(x, r, d, n) - rsd_value(y, r, d, n)
                      : rsd_value(x, r, d, n) + rsd_value(y, r, d, n);
        return e;
    endfunction

    function automatic sb_t mk_dir(input logic [63:0] x, input logic [63:0] y, input bit s,
                                   input logic [63:0] s_exp);
        sb_t e;
        e       = mk_val(x, y, s, R8, D8, W8);
        e.s     = s_exp;
        e.chk_s = 1'b1;
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Results are compared every cycle out_valid is high, so a stalled output is
    // checked against the same entry until it is accepted.
    always @(negedge clock) begin
        sb_t e;
        if (!reset && out_valid) begin
            check_eq("r8_pending", longint'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8[0];
                if (e.chk_s) check_eq("r8_s_out", longint'(s_out), longint'(e.s));
                if (e.chk_val) begin
                    check_eq("r8_value", rsd_value(64'(s_out), R8, D8, W8 + 1), e.val);
                    check_eq("r8_digit_range", range_bad(64'(s_out), R8, D8, W8 + 1), 0);
                end
                check_eq("r8_err_out", longint'(err_out), longint'(e.err));
                if (out_ready) void'(q8.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        sb_t e;
        if (!reset && out_valid4) begin
            check_eq("r4_pending", longint'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e = q4[0];
                check_eq("r4_value", rsd_value(64'(s_out4), R4, D4, W4 + 1), e.val);
                check_eq("r4_digit_range", range_bad(64'(s_out4), R4, D4, W4 + 1), 0);
                check_eq("r4_err_out", longint'(err_out4), 0);
                if (out_ready4) void'(q4.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send8(input logic [N8-1:0] x, input logic [N8-1:0] y, input bit s,
                         input sb_t e);
        int waited = 0;
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        sub      = s;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clock);
        end
        check_eq("r8_accept_in_time", longint'(in_ready), 1);
        if (in_ready) q8.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8_rand();
        logic [63:0] xv, yv;
        bit s;
        xv = rand_op(R8, D8, W8);
        yv = rand_op(R8, D8, W8);
        s  = 1'($urandom_range(0, 1));
        send8(xv[N8-1:0], yv[N8-1:0], s, mk_val(xv, yv, s, R8, D8, W8));
    endtask

    task automatic run_lane4(input int n);
        int acc = 0;
        int cycles = 0;
        logic [63:0] xv, yv;
        bit s;
        while (acc < n && cycles < n * 8) begin
            xv         = rand_op(R4, D4, W4);
            yv         = rand_op(R4, D4, W4);
            s          = 1'($urandom_range(0, 1));
            x_in4      = xv[N4-1:0];
            y_in4      = yv[N4-1:0];
            sub4       = s;
            in_valid4  = ($urandom_range(0, 3) != 0);
            out_ready4 = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_valid4 && in_ready4) begin
                q4.push_back(mk_val(xv, yv, s, R4, D4, W4));
                acc++;
            end
            @(posedge clock);
            #1;
            cycles++;
        end
        check_eq("r4_accepted", acc, n);
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        check_eq("drain", q8.size() + q4.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        in_valid   = 1'b0;
        sub        = 1'b0;
        x_in       = '0;
        y_in       = '0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        sub4       = 1'b0;
        x_in4      = '0;
        y_in4      = '0;
        out_ready4 = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("reset_out_valid", longint'(out_valid), 0);
        check_eq("reset_s_out", longint'(s_out), 0);
        check_eq("reset_err_out", longint'(err_out), 0);
        check_eq("reset_out_valid4", longint'(out_valid4), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_reset", longint'(in_ready), 1);
        @(posedge clock);
        #1;

        // Directed sums with exact expected encodings
        send8(20'h77777, 20'h77777, 1'b0, mk_dir(64'h77777, 64'h77777, 1'b0, 64'h177776));
        @(negedge clock);
        check_eq("latency_edge1", longint'(out_valid), 0);
        @(negedge clock);
        check_eq("latency_edge2", longint'(out_valid), 1);
        @(posedge clock);
        #1;
        send8(20'h99999, 20'h99999, 1'b0, mk_dir(64'h99999, 64'h99999, 1'b0, 64'hF9999A));
        send8(20'h00004, 20'h00003, 1'b0, mk_dir(64'h4, 64'h3, 1'b0, 64'h00001F));
        send8(20'h00004, 20'h00003, 1'b1, mk_dir(64'h4, 64'h3, 1'b1, 64'h000001));
        send8(20'h77777, 20'h99999, 1'b1, mk_dir(64'h77777, 64'h99999, 1'b1, 64'h177776));
        begin
            sb_t e;
            e = '{s: '0, val: 0, chk_s: 1'b0, chk_val: 1'b0, err: 1'b1};
            send8(20'h00008, 20'h00000, 1'b0, e);
        end
        send8(20'h00004, 20'h00003, 1'b1, mk_dir(64'h4, 64'h3, 1'b1, 64'h000001));
        drain();

        // Full throughput with simultaneous accept and emit
        c0 = cyc;
        repeat (8) send8_rand();
        check_eq("throughput_cycles", cyc - c0, 8);
        drain();

        // Backpressure: four in a stream, output stalled for three cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    logic [63:0] xv;
                    xv = 64'(i + 1);
                    send8(xv[N8-1:0], '0, 1'b0, mk_val(xv, 64'h0, 1'b0, R8, D8, W8));
                end
            end
            begin
                repeat (3) @(negedge clock);
                check_eq("in_ready_when_full", longint'(in_ready), 0);
                @(posedge clock);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    check_eq("stream_out_valid", longint'(out_valid), 1);
                end
            end
        join
        drain();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send8(20'h12345, 20'h00321, 1'b0, mk_val(64'h12345, 64'h321, 1'b0, R8, D8, W8));
        send8(20'h00111, 20'h00222, 1'b1, mk_val(64'h111, 64'h222, 1'b1, R8, D8, W8));
        reset = 1'b1;
        @(posedge clock);
        #1;
        q8.delete();
        @(negedge clock);
        check_eq("midreset_out_valid", longint'(out_valid), 0);
        check_eq("midreset_s_out", longint'(s_out), 0);
        check_eq("midreset_err_out", longint'(err_out), 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check_eq("ready_after_midreset", longint'(in_ready), 1);
        @(posedge clock);
        #1;

        // Random legal operands on both radices, random output stalls
        fork
            begin
                rand_ready = 1'b1;
                repeat (5000) send8_rand();
                rand_ready = 1'b0;
                out_ready  = 1'b1;
            end
            run_lane4(5000);
        join
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
